// File: rtl/reg_bus_pkg.sv
// Shared constants for the register-bus arbiter: default widths, the timeout
// read pattern and the controller state encoding.
package reg_bus_pkg;

    localparam int DEF_ASZ = 7;
    localparam int DEF_DSZ = 32;
    localparam logic [31:0] DEF_TIMEOUT_DATA = 32'hDEADBEEF;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first set request after the last
// winner, wrapping modulo NREQ. Reusable for any shared resource.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    always_comb begin
        int cand;
        cand  = 0;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        // Offset 1..NREQ visits last+1 first and last itself at the very end.
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last) + k) % NREQ;
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                idx         = IW'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares one single-outstanding register bus between NREQ requesters.
// Handshake: req is a level held until the one-cycle ack; bus_ready completes
// the downstream access, and TIMEOUT cycles without it completes with err=1.
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int              NREQ         = 2,
    parameter int              ASZ          = DEF_ASZ,
    parameter int              DSZ          = DEF_DSZ,
    parameter int              TIMEOUT      = 16,
    parameter logic [DSZ-1:0]  TIMEOUT_DATA = DSZ'(DEF_TIMEOUT_DATA)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     we,
    input  logic [NREQ*ASZ-1:0] addr,
    input  logic [NREQ*DSZ-1:0] wdata,
    output logic [NREQ-1:0]     ack,
    output logic                err,
    output logic [DSZ-1:0]      rdata,
    output logic                busy,
    output logic                bus_en,
    output logic                bus_we,
    output logic [ASZ-1:0]      bus_addr,
    output logic [DSZ-1:0]      bus_wdata,
    input  logic [DSZ-1:0]      bus_rdata,
    input  logic                bus_ready,
    output logic [1:0]          dbg_state
);

    localparam int IW = idx_width(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    logic [1:0]      state;
    logic [IW-1:0]   ptr;
    logic [NREQ-1:0] win_oh;
    logic [CW-1:0]   cnt;

    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;
    logic            arb_valid;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req   (req),
        .last  (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= IW'(NREQ - 1);
            win_oh    <= '0;
            cnt       <= '0;
            ack       <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            bus_en    <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        win_oh    <= arb_grant;
                        ptr       <= arb_idx;
                        bus_we    <= we[arb_idx];
                        bus_addr  <= addr[int'(arb_idx)*ASZ +: ASZ];
                        bus_wdata <= wdata[int'(arb_idx)*DSZ +: DSZ];
                        bus_en    <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Ready is checked first so it wins on the final counted cycle.
                    if (bus_ready) begin
                        if (!bus_we) rdata <= bus_rdata;
                        err    <= 1'b0;
                        ack    <= win_oh;
                        bus_en <= 1'b0;
                        state  <= ST_DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        rdata  <= TIMEOUT_DATA;
                        err    <= 1'b1;
                        ack    <= win_oh;
                        bus_en <= 1'b0;
                        state  <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Gives the requester one cycle to update req before IDLE samples it.
                    ack   <= '0;
                    err   <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench for reg_bus_arbiter: directed scenarios plus randomized
// accesses against a transaction-level round-robin / timeout model.
module tb_reg_bus_arbiter;
    import reg_bus_pkg::*;

    localparam int NREQ    = 2;
    localparam int ASZ     = 7;
    localparam int DSZ     = 32;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ-1:0]     we = '0;
    logic [NREQ*ASZ-1:0] addr = '0;
    logic [NREQ*DSZ-1:0] wdata = '0;
    logic [NREQ-1:0]     ack;
    logic                err;
    logic [DSZ-1:0]      rdata;
    logic                busy;
    logic                bus_en;
    logic                bus_we;
    logic [ASZ-1:0]      bus_addr;
    logic [DSZ-1:0]      bus_wdata;
    logic [DSZ-1:0]      bus_rdata = '0;
    logic                bus_ready = 1'b0;
    logic [1:0]          dbg_state;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int ack_cyc = 0;
    int prev_ack_cyc = 0;
    int last_m = NREQ - 1;
    logic [DSZ-1:0] rd_m = '0;

    reg_bus_arbiter #(.NREQ(NREQ), .ASZ(ASZ), .DSZ(DSZ), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .bus_en    (bus_en),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++)
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    // One full access: wait for the grant, play a slave with the given wait
    // count (>= TIMEOUT means never ready), then check completion and DONE.
    task automatic serve(input int waits, input logic [DSZ-1:0] rdv, input bit drop_req);
        int w, guard, en_cnt, exp_cycles, c;
        logic exp_we, exp_err;
        logic [DSZ-1:0] exp_rd;
        logic [NREQ-1:0] exp_ack;
        w = rr_pick(last_m, req);
        guard = 0;
        do begin
            @(posedge clk); #1;
            guard++;
        end while (bus_en !== 1'b1 && guard < 8);
        checks++;
        if (bus_en !== 1'b1) begin
            fails++;
            $display("FAIL grant_wait: bus_en=%b required 1 within 8 cycles", bus_en);
            return;
        end
        exp_we = we[w];
        checks++;
        if (bus_addr !== addr[w*ASZ +: ASZ] || bus_we !== exp_we ||
            bus_wdata !== wdata[w*DSZ +: DSZ] || busy !== 1'b1) begin
            fails++;
            $display("FAIL grant_fields: winner %0d addr=%h we=%b wdata=%h busy=%b required addr=%h we=%b wdata=%h busy=1",
                     w, bus_addr, bus_we, bus_wdata, busy, addr[w*ASZ +: ASZ], exp_we, wdata[w*DSZ +: DSZ]);
        end
        last_m = w;
        if (drop_req) req[w] = 1'b0;
        en_cnt = 1;
        for (c = 0; c < TIMEOUT + 4; c++) begin
            bus_ready = (c == waits);
            bus_rdata = rdv;
            @(posedge clk); #1;
            bus_ready = 1'b0;
            bus_rdata = $urandom;
            if (bus_en === 1'b1) en_cnt++;
            if (ack !== '0) break;
        end
        if (waits < TIMEOUT) begin
            exp_cycles = waits + 1;
            exp_err    = 1'b0;
            exp_rd     = exp_we ? rd_m : rdv;
        end else begin
            exp_cycles = TIMEOUT;
            exp_err    = 1'b1;
            exp_rd     = 32'hDEADBEEF;
        end
        exp_ack = '0;
        exp_ack[w] = 1'b1;
        prev_ack_cyc = ack_cyc;
        ack_cyc = cyc;
        checks++;
        if (ack !== exp_ack) begin
            fails++;
            $display("FAIL ack: got %b required %b", ack, exp_ack);
        end
        checks++;
        if (err !== exp_err || rdata !== exp_rd) begin
            fails++;
            $display("FAIL completion: err=%b rdata=%h required err=%b rdata=%h", err, rdata, exp_err, exp_rd);
        end
        checks++;
        if (en_cnt !== exp_cycles) begin
            fails++;
            $display("FAIL bus_en_cycles: got %0d required %0d", en_cnt, exp_cycles);
        end
        rd_m = exp_rd;
        @(posedge clk); #1;
        checks++;
        if (ack !== '0 || err !== 1'b0 || busy !== 1'b0 || bus_en !== 1'b0 || rdata !== rd_m) begin
            fails++;
            $display("FAIL done: ack=%b err=%b busy=%b bus_en=%b rdata=%h required 0 0 0 0 %h",
                     ack, err, busy, bus_en, rdata, rd_m);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (ack !== '0 || err !== 1'b0 || rdata !== '0 || busy !== 1'b0 || bus_en !== 1'b0 ||
            bus_we !== 1'b0 || bus_addr !== '0 || bus_wdata !== '0 || dbg_state !== ST_IDLE) begin
            fails++;
            $display("FAIL %s: ack=%b err=%b rdata=%h busy=%b bus_en=%b bus_we=%b bus_addr=%h bus_wdata=%h state=%0d required all 0",
                     name, ack, err, rdata, busy, bus_en, bus_we, bus_addr, bus_wdata, dbg_state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        req = 2'b11;
        we = 2'b00;
        addr[0 +: ASZ] = 7'h11;
        addr[ASZ +: ASZ] = 7'h22;
        @(negedge clk);
        rst = 1'b0;
        serve(0, 32'h0000_1111, 1'b0);
        checks++;
        if (last_m !== 0) begin
            fails++;
            $display("FAIL first_grant: winner %0d required 0", last_m);
        end
    endtask

    task automatic test_alternate();
        int first;
        req = 2'b11;
        first = last_m;
        for (int i = 0; i < 4; i++) begin
            serve(0, $urandom, 1'b0);
            checks++;
            if (last_m !== (first + 1 + i) % NREQ) begin
                fails++;
                $display("FAIL alternate_winner: got %0d required %0d", last_m, (first + 1 + i) % NREQ);
            end
            if (i > 0) begin
                checks++;
                if (ack_cyc - prev_ack_cyc !== 3) begin
                    fails++;
                    $display("FAIL ack_spacing: got %0d cycles required 3", ack_cyc - prev_ack_cyc);
                end
            end
        end
    endtask

    task automatic test_wait_read();
        req = 2'b01;
        we[0] = 1'b0;
        serve(3, 32'h12345678, 1'b0);
    endtask

    task automatic test_timeout();
        req = 2'b10;
        we[1] = 1'b0;
        serve(TIMEOUT + 5, 32'h0BAD_0BAD, 1'b0);
        serve(TIMEOUT - 1, 32'h5555_AAAA, 1'b0);
    endtask

    task automatic test_write();
        req = 2'b01;
        we[0] = 1'b0;
        serve(0, 32'hCAFE_F00D, 1'b0);
        we[0] = 1'b1;
        addr[0 +: ASZ] = 7'h05;
        wdata[0 +: DSZ] = 32'hA5A5A5A5;
        serve(2, 32'h7777_7777, 1'b0);
    endtask

    task automatic test_drop_req();
        req = 2'b11;
        serve(1, 32'h0102_0304, 1'b1);
        serve(0, 32'h0506_0708, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            we = NREQ'($urandom);
            for (int r = 0; r < NREQ; r++) begin
                addr[r*ASZ +: ASZ] = ASZ'($urandom);
                wdata[r*DSZ +: DSZ] = $urandom;
            end
            serve(($urandom_range(0, 3) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 2)
                                             : $urandom_range(0, 4),
                  $urandom, $urandom_range(0, 3) == 0);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        req = 2'b01;
        we = 2'b00;
        guard = 0;
        do begin
            @(posedge clk); #1;
            guard++;
        end while (bus_en !== 1'b1 && guard < 8);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid_access");
        req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ack !== '0 || bus_en !== 1'b0) begin
                fails++;
                $display("FAIL ack_in_reset: ack=%b bus_en=%b required 0 0", ack, bus_en);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        last_m = NREQ - 1;
        rd_m = '0;
        serve(0, 32'h2468_ACE0, 1'b0);
        checks++;
        if (last_m !== 0) begin
            fails++;
            $display("FAIL grant_after_reset: winner %0d required 0", last_m);
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_wait_read();
        test_timeout();
        test_write();
        test_drop_req();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

endmodule
